uart_fb_loader: RTL

Parametrised UART-to-framebuffer write engine. Sits between uart_receiver (byte + done pulse) and the single-port frame RAM write port. It unpacks several pixels per byte, generates wrap-safe pixel addresses, and supports two modes: raw streaming, and framed packets that carry an explicit start address and length. It reports overrun, range and timeout errors.

---
 rtl/uart_fb_pkg.sv | 26 ++
 rtl/fb_pix_unpacker.sv | 50 +++++
 rtl/uart_fb_loader.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/uart_fb_pkg.sv
// Shared types and helpers for the UART-to-framebuffer loader.
package uart_fb_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StA0,
        StA1,
        StA2,
        StL0,
        StL1,
        StPayload,
        StRaw
    } fb_state_e;

    localparam logic [7:0] DefaultSyncByte = 8'hA5;

    function automatic int unsigned calc_ppb(input int unsigned bpp);
        return 8 / bpp;
    endfunction

    function automatic int unsigned calc_max_addr(input int unsigned h_pix,
                                                  input int unsigned v_pix);
        return h_pix * v_pix;
    endfunction

endpackage

// File: rtl/fb_pix_unpacker.sv
// Splits one byte into PPB pixels, LSB-first, one pixel per cycle.
module fb_pix_unpacker
    import uart_fb_pkg::*;
#(
    parameter int unsigned BPP = 3,
    parameter int unsigned PPB = calc_ppb(BPP)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           load,
    input  logic [7:0]     byte_in,
    output logic [BPP-1:0] pix,
    output logic           pix_valid,
    output logic           pix_last,
    output logic           busy
);

    localparam int unsigned CntW = $clog2(PPB + 1);

    logic [7:0]      sh_q, sh_d;
    logic [CntW-1:0] cnt_q, cnt_d;

    always_comb begin
        sh_d  = sh_q;
        cnt_d = cnt_q;
        if (load && (cnt_q == '0)) begin
            sh_d  = byte_in;
            cnt_d = CntW'(PPB);
        end else if (cnt_q != '0) begin
            sh_d  = sh_q >> BPP;
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_q  <= '0;
            cnt_q <= '0;
        end else begin
            sh_q  <= sh_d;
            cnt_q <= cnt_d;
        end
    end

    assign pix       = sh_q[BPP-1:0];
    assign pix_valid = (cnt_q != '0);
    assign pix_last  = (cnt_q == CntW'(1));
    assign busy      = pix_valid;

endmodule

// File: rtl/uart_fb_loader.sv
// UART byte stream to frame RAM writer: raw streaming or framed packets with
// explicit start address and length, plus sticky overrun/range/timeout flags.
module uart_fb_loader
    import uart_fb_pkg::*;
#(
    parameter int unsigned H_PIX     = 640,
    parameter int unsigned V_PIX     = 480,
    parameter int unsigned BPP       = 3,
    parameter int unsigned ADDR_W    = 19,
    parameter logic [7:0]  SYNC_BYTE = DefaultSyncByte,
    parameter int unsigned TIMEOUT   = 20000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mode,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    input  logic              clr_err,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [BPP-1:0]    wr_data,
    output logic              wr_en,
    output logic              busy,
    output logic              frame_done,
    output logic              err_overrun,
    output logic              err_range,
    output logic              err_timeout
);

    localparam int unsigned PPB      = calc_ppb(BPP);
    localparam int unsigned MAX_ADDR = calc_max_addr(H_PIX, V_PIX);
    localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(MAX_ADDR - 1);
    localparam int unsigned ToW = $clog2(TIMEOUT + 1);
    localparam logic [ToW-1:0] ToLast = ToW'(TIMEOUT - 1);

    function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a);
        return (a == LastAddr) ? '0 : a + 1'b1;
    endfunction

    fb_state_e         state_q, state_d;
    logic [ADDR_W-1:0] raw_addr_q, raw_addr_d;
    logic [ADDR_W-1:0] pkt_addr_q, pkt_addr_d;
    logic [15:0]       hdr_lo_q, hdr_lo_d;
    logic [7:0]        len_lo_q, len_lo_d;
    logic [15:0]       len_q, len_d;
    logic [ToW-1:0]    to_q, to_d;
    logic              unp_raw_q, unp_raw_d;
    logic              done_q, done_d;
    logic              ovr_q, rng_q, tmo_q;
    logic              set_ovr, set_rng, set_tmo;
    logic              accept, load;
    logic [BPP-1:0]    pix;
    logic              pix_valid, pix_last, unp_busy;

    fb_pix_unpacker #(
        .BPP (BPP),
        .PPB (PPB)
    ) u_unpacker (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (load),
        .byte_in   (rx_data),
        .pix       (pix),
        .pix_valid (pix_valid),
        .pix_last  (pix_last),
        .busy      (unp_busy)
    );

    assign accept  = rx_valid && !unp_busy;
    assign set_ovr = rx_valid && unp_busy;

    always_comb begin
        state_d    = state_q;
        raw_addr_d = raw_addr_q;
        pkt_addr_d = pkt_addr_q;
        hdr_lo_d   = hdr_lo_q;
        len_lo_d   = len_lo_q;
        len_d      = len_q;
        to_d       = to_q;
        unp_raw_d  = unp_raw_q;
        done_d     = 1'b0;
        set_rng    = 1'b0;
        set_tmo    = 1'b0;
        load       = 1'b0;

        // The address of whichever stream owns the unpacker advances per pixel.
        if (pix_valid) begin
            if (unp_raw_q) begin
                raw_addr_d = next_addr(raw_addr_q);
                done_d     = (raw_addr_q == LastAddr);
            end else begin
                pkt_addr_d = next_addr(pkt_addr_q);
            end
        end

        case (state_q)
            StIdle: begin
                if (accept) begin
                    if (!mode) begin
                        load      = 1'b1;
                        unp_raw_d = 1'b1;
                        state_d   = StRaw;
                    end else if (rx_data == SYNC_BYTE) begin
                        state_d = StA0;
                    end
                end
            end
            StA0: if (accept) begin
                hdr_lo_d[7:0] = rx_data;
                state_d       = StA1;
            end
            StA1: if (accept) begin
                hdr_lo_d[15:8] = rx_data;
                state_d        = StA2;
            end
            StA2: if (accept) begin
                pkt_addr_d = ADDR_W'({rx_data, hdr_lo_q});
                state_d    = StL0;
            end
            StL0: if (accept) begin
                len_lo_d = rx_data;
                state_d  = StL1;
            end
            StL1: if (accept) begin
                if (32'(pkt_addr_q) >= MAX_ADDR) begin
                    set_rng = 1'b1;
                    state_d = StIdle;
                end else if ({rx_data, len_lo_q} == 16'd0) begin
                    done_d  = 1'b1;
                    state_d = StIdle;
                end else begin
                    len_d   = {rx_data, len_lo_q};
                    state_d = StPayload;
                end
            end
            StPayload: begin
                if (accept && (len_q != 16'd0)) begin
                    load      = 1'b1;
                    unp_raw_d = 1'b0;
                    len_d     = len_q - 1'b1;
                end
                // len_q already counts the byte being unpacked as consumed.
                if (pix_last && !unp_raw_q && (len_q == 16'd0)) begin
                    done_d  = 1'b1;
                    state_d = StIdle;
                end
            end
            StRaw: if (pix_last) state_d = StIdle;
            default: state_d = StIdle;
        endcase

        if (state_q == StIdle) begin
            to_d = '0;
        end else if (accept) begin
            to_d = '0;
        end else if (to_q == ToLast) begin
            to_d    = '0;
            set_tmo = 1'b1;
            state_d = StIdle;
        end else begin
            to_d = to_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            raw_addr_q <= '0;
            pkt_addr_q <= '0;
            hdr_lo_q   <= '0;
            len_lo_q   <= '0;
            len_q      <= '0;
            to_q       <= '0;
            unp_raw_q  <= 1'b0;
            done_q     <= 1'b0;
            ovr_q      <= 1'b0;
            rng_q      <= 1'b0;
            tmo_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            raw_addr_q <= raw_addr_d;
            pkt_addr_q <= pkt_addr_d;
            hdr_lo_q   <= hdr_lo_d;
            len_lo_q   <= len_lo_d;
            len_q      <= len_d;
            to_q       <= to_d;
            unp_raw_q  <= unp_raw_d;
            done_q     <= done_d;
            // A set in the same cycle as clr_err wins.
            ovr_q      <= (ovr_q & ~clr_err) | set_ovr;
            rng_q      <= (rng_q & ~clr_err) | set_rng;
            tmo_q      <= (tmo_q & ~clr_err) | set_tmo;
        end
    end

    assign wr_addr     = unp_raw_q ? raw_addr_q : pkt_addr_q;
    assign wr_data     = pix;
    assign wr_en       = pix_valid;
    assign busy        = unp_busy;
    assign frame_done  = done_q;
    assign err_overrun = ovr_q;
    assign err_range   = rng_q;
    assign err_timeout = tmo_q;

endmodule
